// File: rtl/execute_stage_mdu_pkg.sv
// Shared encodings for the execute stage: MDU ops, forwarding selects,
// MDU FSM states and ALU control codes.
package execute_stage_mdu_pkg;

    typedef logic [2:0] mdu_op_t;
    localparam mdu_op_t MDU_NONE  = 3'd0;
    localparam mdu_op_t MDU_MULTU = 3'd1;
    localparam mdu_op_t MDU_MULT  = 3'd2;
    localparam mdu_op_t MDU_DIVU  = 3'd3;
    localparam mdu_op_t MDU_DIV   = 3'd4;
    localparam mdu_op_t MDU_MFHI  = 3'd5;
    localparam mdu_op_t MDU_MFLO  = 3'd6;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_REG = 2'd0;
    localparam fwd_sel_t FWD_MEM = 2'd1;
    localparam fwd_sel_t FWD_WB  = 2'd2;

    typedef logic [1:0] mdu_state_t;
    localparam mdu_state_t ST_IDLE = 2'd0;
    localparam mdu_state_t ST_BUSY = 2'd1;
    localparam mdu_state_t ST_DONE = 2'd2;

    typedef logic [5:0] alu_ctrl_t;
    localparam alu_ctrl_t ALU_SLL  = 6'h00;
    localparam alu_ctrl_t ALU_SRL  = 6'h02;
    localparam alu_ctrl_t ALU_SRA  = 6'h03;
    localparam alu_ctrl_t ALU_ADD  = 6'h20;
    localparam alu_ctrl_t ALU_ADDU = 6'h21;
    localparam alu_ctrl_t ALU_SUB  = 6'h22;
    localparam alu_ctrl_t ALU_SUBU = 6'h23;
    localparam alu_ctrl_t ALU_AND  = 6'h24;
    localparam alu_ctrl_t ALU_OR   = 6'h25;
    localparam alu_ctrl_t ALU_XOR  = 6'h26;
    localparam alu_ctrl_t ALU_NOR  = 6'h27;
    localparam alu_ctrl_t ALU_SLT  = 6'h2A;
    localparam alu_ctrl_t ALU_SLTU = 6'h2B;

    // True for the ops that occupy the iterative unit
    function automatic logic is_mdu_arith(input mdu_op_t op);
        return (op == MDU_MULTU) || (op == MDU_MULT) ||
               (op == MDU_DIVU)  || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/execute_stage_mdu_if.sv
// Decode-to-execute and execute-to-memory signal bundle.
interface execute_stage_mdu_if #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int CTRL_W  = 6
);
    logic                i_valid;
    logic                o_ready;
    logic                i_hold;
    logic                i_flush;
    logic [DATA_W-1:0]   i_op1;
    logic [DATA_W-1:0]   i_op2;
    logic [DATA_W-1:0]   i_fwd_mem;
    logic [DATA_W-1:0]   i_fwd_wb;
    logic [1:0]          i_fwd_sel1;
    logic [1:0]          i_fwd_sel2;
    logic [IMM_W-1:0]    i_imm;
    logic [SHAMT_W-1:0]  i_shamt;
    logic                i_extop;
    logic                i_alusrc1;
    logic                i_alusrc2;
    logic [CTRL_W-1:0]   i_aluctrl;
    logic [2:0]          i_mduop;
    logic                o_valid;
    logic [DATA_W-1:0]   o_alures;
    logic [DATA_W-1:0]   o_op2;
    logic                o_ovf;
    logic                o_zf;
    logic                o_mdu_busy;

    modport master (
        output i_valid, i_hold, i_flush, i_op1, i_op2, i_fwd_mem, i_fwd_wb,
               i_fwd_sel1, i_fwd_sel2, i_imm, i_shamt, i_extop, i_alusrc1,
               i_alusrc2, i_aluctrl, i_mduop,
        input  o_ready, o_valid, o_alures, o_op2, o_ovf, o_zf, o_mdu_busy
    );

    modport slave (
        input  i_valid, i_hold, i_flush, i_op1, i_op2, i_fwd_mem, i_fwd_wb,
               i_fwd_sel1, i_fwd_sel2, i_imm, i_shamt, i_extop, i_alusrc1,
               i_alusrc2, i_aluctrl, i_mduop,
        output o_ready, o_valid, o_alures, o_op2, o_ovf, o_zf, o_mdu_busy
    );
endinterface

// File: rtl/execute_stage_mdu_mdu_iter.sv
// Iterative multiply/divide unit: one bit per cycle on magnitudes,
// sign fix-up and HI/LO write in the DONE cycle.
module mdu_iter
    import execute_stage_mdu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  mdu_op_t           op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    mdu_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   acc;
    logic [DATA_W-1:0]     opb_mag;
    logic [DATA_W-1:0]     dividend_raw;
    logic                  is_div;
    logic                  neg_main;
    logic                  neg_rem;
    logic                  div_zero;

    logic                  signed_op;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_W-1:0]     a_mag;
    logic [DATA_W-1:0]     b_mag;
    logic [DATA_W-1:0]     acc_hi;
    logic [DATA_W-1:0]     acc_lo;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_sh;
    logic [DATA_W:0]       div_diff;
    logic [2*DATA_W-1:0]   acc_step;
    logic [2*DATA_W-1:0]   prod_fix;
    logic [DATA_W-1:0]     quot_fix;
    logic [DATA_W-1:0]     rem_fix;

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);

    // Operand magnitudes latched at start
    always_comb begin
        signed_op = (op == MDU_MULT) || (op == MDU_DIV);
        a_neg     = signed_op & op_a[DATA_W-1];
        b_neg     = signed_op & op_b[DATA_W-1];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;
    end

    // One iteration: shift-add multiply (low half holds the multiplier)
    // or restoring divide (low half holds the dividend, quotient shifts in)
    always_comb begin
        acc_hi   = acc[2*DATA_W-1:DATA_W];
        acc_lo   = acc[DATA_W-1:0];
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_mag} : '0);
        div_sh   = {acc_hi, acc_lo[DATA_W-1]};
        div_diff = div_sh - {1'b0, opb_mag};
        if (is_div) begin
            if (div_diff[DATA_W])
                acc_step = {div_sh[DATA_W-1:0], acc_lo[DATA_W-2:0], 1'b0};
            else
                acc_step = {div_diff[DATA_W-1:0], acc_lo[DATA_W-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_lo[DATA_W-1:1]};
        end
        prod_fix = neg_main ? -acc : acc;
        quot_fix = neg_main ? -acc_lo : acc_lo;
        rem_fix  = neg_rem ? -acc_hi : acc_hi;
    end

    // FSM, counter, datapath and HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            acc          <= '0;
            opb_mag      <= '0;
            dividend_raw <= '0;
            is_div       <= 1'b0;
            neg_main     <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_BUSY;
                        cnt          <= '0;
                        acc          <= {{DATA_W{1'b0}}, a_mag};
                        opb_mag      <= b_mag;
                        dividend_raw <= op_a;
                        is_div       <= (op == MDU_DIVU) || (op == MDU_DIV);
                        neg_main     <= a_neg ^ b_neg;
                        neg_rem      <= a_neg;
                        div_zero     <= (op_b == '0);
                    end
                end
                ST_BUSY: begin
                    if (!hold) begin
                        acc <= acc_step;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state <= ST_DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (div_zero) begin
                        hi <= dividend_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage_mdu.sv
// Registered MIPS execute stage: forwarding, operand selection, ALU,
// iterative MDU with HI/LO, and the EX/MEM pipeline register.
module execute_stage_mdu
    import execute_stage_mdu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int CTRL_W  = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    execute_stage_mdu_if.slave   ex
);

    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic [DATA_W-1:0] res_next;
    logic              ovf_next;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              mdu_busy;
    logic              mdu_done;
    logic              ready;
    logic              accept;
    logic              mdu_start;

    assign ready         = ~(mdu_busy | mdu_done);
    assign ex.o_ready    = ready;
    assign ex.o_mdu_busy = mdu_busy;
    assign accept        = ex.i_valid & ready & ~ex.i_hold;
    assign mdu_start     = accept & ~ex.i_flush & is_mdu_arith(ex.i_mduop);
    assign imm_ext       = {{(DATA_W-IMM_W){ex.i_extop & ex.i_imm[IMM_W-1]}}, ex.i_imm};

    // Forwarding ahead of the source-select muxes
    always_comb begin
        case (ex.i_fwd_sel1)
            FWD_MEM: fwd1 = ex.i_fwd_mem;
            FWD_WB:  fwd1 = ex.i_fwd_wb;
            default: fwd1 = ex.i_op1;
        endcase
        case (ex.i_fwd_sel2)
            FWD_MEM: fwd2 = ex.i_fwd_mem;
            FWD_WB:  fwd2 = ex.i_fwd_wb;
            default: fwd2 = ex.i_op2;
        endcase
        src_a = ex.i_alusrc1 ? {{(DATA_W-SHAMT_W){1'b0}}, ex.i_shamt} : fwd1;
        src_b = ex.i_alusrc2 ? imm_ext : fwd2;
    end

    // ALU; overflow only meaningful for signed add/sub
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_ctrl_t'(ex.i_aluctrl))
            ALU_ADD: begin
                alu_res = src_a + src_b;
                alu_ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != src_a[DATA_W-1]);
            end
            ALU_ADDU: alu_res = src_a + src_b;
            ALU_SUB: begin
                alu_res = src_a - src_b;
                alu_ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != src_a[DATA_W-1]);
            end
            ALU_SUBU: alu_res = src_a - src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_NOR:  alu_res = ~(src_a | src_b);
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, src_a < src_b};
            ALU_SLL:  alu_res = src_b << src_a[SHAMT_W-1:0];
            ALU_SRL:  alu_res = src_b >> src_a[SHAMT_W-1:0];
            ALU_SRA:  alu_res = $signed(src_b) >>> src_a[SHAMT_W-1:0];
            default:  alu_res = '0;
        endcase
    end

    // Result select: HI/LO moves, zero for issuing MDU ops, else ALU
    always_comb begin
        res_next = alu_res;
        ovf_next = alu_ovf;
        case (mdu_op_t'(ex.i_mduop))
            MDU_MFHI: begin res_next = hi; ovf_next = 1'b0; end
            MDU_MFLO: begin res_next = lo; ovf_next = 1'b0; end
            MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV: begin
                res_next = '0;
                ovf_next = 1'b0;
            end
            default: ;
        endcase
    end

    mdu_iter #(
        .DATA_W (DATA_W),
        .CNT_W  (SHAMT_W)
    ) u_mdu (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .start (mdu_start),
        .hold  (ex.i_hold),
        .op    (mdu_op_t'(ex.i_mduop)),
        .op_a  (fwd1),
        .op_b  (fwd2),
        .busy  (mdu_busy),
        .done  (mdu_done),
        .hi    (hi),
        .lo    (lo)
    );

    // EX/MEM register; flush beats hold for the valid bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex.o_valid  <= 1'b0;
            ex.o_alures <= '0;
            ex.o_op2    <= '0;
            ex.o_ovf    <= 1'b0;
            ex.o_zf     <= 1'b0;
        end else if (ex.i_flush) begin
            ex.o_valid <= 1'b0;
        end else if (!ex.i_hold) begin
            ex.o_valid <= accept;
            if (accept) begin
                ex.o_alures <= res_next;
                ex.o_op2    <= fwd2;
                ex.o_ovf    <= ovf_next;
                ex.o_zf     <= (res_next == '0);
            end
        end
    end

endmodule

// File: doc/execute_stage_mdu.md
Name: execute_stage_mdu

Overview:
Registered execute stage for the pipelined MIPS core, parametrised in datapath width. Performs immediate extension, shift-amount selection, two-source operand forwarding and the single-cycle ALU operation. Adds an iterative multiply/divide unit (MDU) with HI/LO registers and a stall handshake toward decode. Drives the EX/MEM pipeline register directly.

Parameters:
DATA_W, 32, datapath and HI/LO width; must be ≥ 8.
IMM_W, 16, immediate field width; must be < DATA_W.
SHAMT_W, 5, shift-amount width; equals clog2(DATA_W).
CTRL_W, 6, ALU control code width.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  decode presents an instruction
o_ready  out  1  stage accepts; low while MDU busy
i_hold  in  1  downstream stall; freezes output register and MDU counter
i_flush  in  1  squash the instruction being registered this cycle
i_op1, i_op2  in  DATA_W  register-file operands
i_fwd_mem, i_fwd_wb  in  DATA_W  forwarded results
i_fwd_sel1, i_fwd_sel2  in  2  0=regfile, 1=mem, 2=wb, 3=reserved→regfile
i_imm  in  IMM_W  immediate
i_shamt  in  SHAMT_W  shift amount
i_extop  in  1  1=sign-extend, 0=zero-extend
i_alusrc1  in  1  1=op1 is zero-extended shamt
i_alusrc2  in  1  1=op2 is extended immediate
i_aluctrl  in  CTRL_W  ALU operation
i_mduop  in  3  0 none, 1 MULTU, 2 MULT, 3 DIVU, 4 DIV, 5 MFHI, 6 MFLO, 7 reserved=none
o_valid  out  1  EX/MEM register holds a live instruction
o_alures  out  DATA_W  ALU result, or HI/LO for MFHI/MFLO
o_op2  out  DATA_W  forwarded op2, for stores
o_ovf  out  1  ALU signed overflow
o_zf  out  1  o_alures == 0
o_mdu_busy  out  1  MDU iterating

Behaviour:
- Reset, asynchronous: o_valid=0; o_alures, o_op2, o_ovf, o_zf=0; HI=LO=0; FSM=IDLE; counter=0; o_ready=1.
- Accept when i_valid & o_ready & ~i_hold. Results are registered one cycle after accept. No combinational path from inputs to outputs except i_valid/i_hold into o_ready.
- Forwarding mux precedes the source muxes. o_op2 is the forwarded op2, never the immediate.
- ALU semantics are unchanged from the existing core: add/sub/logic/slt/shifts. Overflow is flagged on signed add/sub only, and the result is still written.
- MDU FSM IDLE→BUSY on an accepted op 1–4. Operands are latched as magnitudes (signed ops) or raw values (unsigned ops).
- BUSY lasts exactly DATA_W cycles: shift-add multiply or restoring divide, one bit per cycle. BUSY→DONE, then DONE writes HI/LO and returns to IDLE. Total occupancy is DATA_W+1 cycles.
- o_ready=0 in BUSY and DONE. i_hold freezes the counter.
- The issuing MULT/DIV produces o_valid=1 with o_alures=0 and no writeback. Downstream decodes that.
- MULT: {HI,LO}=product, with sign correction applied in DONE.
- DIV: LO=quotient, HI=remainder. The remainder takes the sign of the dividend.
- Divide by zero: HI=dividend, LO=all-ones. No trap.
- Signed DIV of min/-1: LO=min, HI=0.
- MFHI/MFLO in IDLE read HI/LO directly. While busy they are blocked by o_ready=0, so they never observe partial values.
- i_flush: the registered o_valid becomes 0 and other outputs may update. If the flushed instruction is an MDU op, the FSM does not start. An MDU op already in flight completes.
- i_flush and i_hold together: flush wins. o_valid is cleared and the MDU counter still freezes.
- Reset mid-operation: immediate abort to the reset state. HI/LO are cleared.

Decomposition:
- Shared package: MDU op encodings, forwarding select encodings, and the FSM state typedef (IDLE, BUSY, DONE).
- One sub-module, mdu_iter: FSM, counter, HI/LO, and sign fix-up, with start/busy/done handshake.
- The existing alu, sign-extender and mux modules are reused at width DATA_W.

Test Plan:
- Forwarding: i_op1=1, i_fwd_mem=0x10, sel1=1, op2=2, ADD → o_alures=0x12 next cycle; sel1=2 with i_fwd_wb=5 → 7.
- Immediate and shift: imm=0xFFFF, extop=1, alusrc2=1, op1=1, ADD → 0; extop=0 → 0x00010000. SLL with shamt=4, op2=3 → 0x30.
- MULT: -3 × 5 → o_ready low 33 cycles, then MFLO=0xFFFFFFF1 and MFHI=0xFFFFFFFF. MULTU 0xFFFFFFFF² → HI=0xFFFFFFFE, LO=1.
- Divide: DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → HI=7, LO=0xFFFFFFFF. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
- Hold and flush: i_hold for 5 cycles mid-MULT → completes after 38 cycles total. Flush on MULT issue → o_valid=0, HI/LO unchanged, o_ready stays 1.
- Reset mid-DIV at cycle 10: o_mdu_busy=0, HI=LO=0 and o_valid=0 asynchronously. The next MFHI returns 0.
